// File: rtl/lru_pkg.sv
// -----------------------------------------------------------------------------
// lru_pkg
// Shared types and default sizes for the per-set true-LRU replacement tracker.
//   lru_op_e      : update opcode carried on op_i (NOP / TOUCH / FILL / INVAL)
//   flush_state_e : state of the full-array flush sweep
// -----------------------------------------------------------------------------
package lru_pkg;

    localparam int LRU_NUM_SETS = 64;
    localparam int LRU_NUM_WAYS = 4;

    typedef enum logic [1:0] {
        LRU_NOP   = 2'd0,
        LRU_TOUCH = 2'd1,
        LRU_FILL  = 2'd2,
        LRU_INVAL = 2'd3
    } lru_op_e;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_SWEEP = 1'b1
    } flush_state_e;

endpackage

// File: rtl/lru_set_update.sv
// -----------------------------------------------------------------------------
// lru_set_update
// Purely combinational LRU logic for one cache set.
//   age_i / vld_i   : current way ages (0 = MRU) and valid bits of the op set
//   op_i / way_i    : update to apply
//   age_o / vld_o   : next-state ages and valid bits of the op set
//   qryAge_i/Vld_i  : ages and valid bits of the set being queried
//   victimWay_o     : lowest invalid way, else the way whose age is NUM_WAYS-1
//   victimEvict_o   : valid bit of the chosen victim way
// -----------------------------------------------------------------------------
import lru_pkg::*;

module lru_set_update #(
    parameter  int NUM_WAYS = LRU_NUM_WAYS,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0][WAY_W-1:0] age_i,
    input  logic [NUM_WAYS-1:0]            vld_i,
    input  lru_op_e                        op_i,
    input  logic [WAY_W-1:0]               way_i,
    output logic [NUM_WAYS-1:0][WAY_W-1:0] age_o,
    output logic [NUM_WAYS-1:0]            vld_o,
    input  logic [NUM_WAYS-1:0][WAY_W-1:0] qryAge_i,
    input  logic [NUM_WAYS-1:0]            qryVld_i,
    output logic [WAY_W-1:0]               victimWay_o,
    output logic                           victimEvict_o
);

    logic [WAY_W-1:0] tgtAge;
    logic             foundFree;

    assign tgtAge = age_i[way_i];

    // Age update: promoting a way to MRU ages every younger way by one;
    // invalidating a way demotes it to LRU and pulls every older way up by one.
    // Either way the ages stay a permutation of 0..NUM_WAYS-1.
    always_comb begin
        age_o = age_i;
        vld_o = vld_i;
        case (op_i)
            LRU_TOUCH, LRU_FILL: begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == way_i) begin
                        age_o[w] = '0;
                    end else if (age_i[w] < tgtAge) begin
                        age_o[w] = age_i[w] + WAY_W'(1);
                    end
                end
                if (op_i == LRU_FILL) begin
                    vld_o[way_i] = 1'b1;
                end
            end
            LRU_INVAL: begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (WAY_W'(w) == way_i) begin
                        age_o[w] = WAY_W'(NUM_WAYS - 1);
                    end else if (age_i[w] > tgtAge) begin
                        age_o[w] = age_i[w] - WAY_W'(1);
                    end
                end
                vld_o[way_i] = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Victim select: an empty way always wins over evicting live data.
    always_comb begin
        victimWay_o = '0;
        foundFree   = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!foundFree && !qryVld_i[w]) begin
                victimWay_o = WAY_W'(w);
                foundFree   = 1'b1;
            end
        end
        if (!foundFree) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (qryAge_i[w] == WAY_W'(NUM_WAYS - 1)) begin
                    victimWay_o = WAY_W'(w);
                end
            end
        end
        victimEvict_o = qryVld_i[victimWay_o];
    end

endmodule

// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
// Multi-set true-LRU replacement tracker for an N-way set-associative cache.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   op_i/op_set_i/op_way_i : TOUCH / FILL / INVAL update, applied at the edge
//   op_ready_o             : updates accepted (low during a flush sweep)
//   query_valid_i/set_i    : victim query, answered one cycle later
//   victim_valid_o         : one-cycle pulse with the query answer
//   victim_way_o/evict_o   : chosen way and whether it holds valid data
//   flush_i / busy_o       : start a sweep resetting every set / sweep running
// -----------------------------------------------------------------------------
import lru_pkg::*;

module lru_tracker #(
    parameter  int NUM_SETS = LRU_NUM_SETS,
    parameter  int NUM_WAYS = LRU_NUM_WAYS,
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [1:0]       op_i,
    input  logic [SET_W-1:0] op_set_i,
    input  logic [WAY_W-1:0] op_way_i,
    output logic             op_ready_o,
    input  logic             query_valid_i,
    input  logic [SET_W-1:0] query_set_i,
    output logic             victim_valid_o,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             victim_evict_o,
    input  logic             flush_i,
    output logic             busy_o
);

    typedef logic [NUM_WAYS-1:0][WAY_W-1:0] ageVec_t;

    // Reset image of one set: way w starts with age w, nothing valid.
    function automatic ageVec_t resetAge();
        ageVec_t a;
        for (int w = 0; w < NUM_WAYS; w++) begin
            a[w] = WAY_W'(w);
        end
        return a;
    endfunction

    ageVec_t             age_q [NUM_SETS];
    logic [NUM_WAYS-1:0] vld_q [NUM_SETS];

    flush_state_e        state_q, state_d;
    logic [SET_W-1:0]    sweepCnt_q, sweepCnt_d;

    logic                victimValid_q;
    logic [WAY_W-1:0]    victimWay_q;
    logic                victimEvict_q;

    lru_op_e             opEff;
    ageVec_t             opAge_d;
    logic [NUM_WAYS-1:0] opVld_d;
    logic [WAY_W-1:0]    qryVictim_d;
    logic                qryEvict_d;
    logic                sweeping;

    assign sweeping = (state_q == FL_SWEEP);

    // Updates are dropped while the sweep owns the array.
    assign opEff = sweeping ? LRU_NOP : lru_op_e'(op_i);

    lru_set_update #(
        .NUM_WAYS (NUM_WAYS)
    ) u_setUpdate (
        .age_i         (age_q[op_set_i]),
        .vld_i         (vld_q[op_set_i]),
        .op_i          (opEff),
        .way_i         (op_way_i),
        .age_o         (opAge_d),
        .vld_o         (opVld_d),
        .qryAge_i      (age_q[query_set_i]),
        .qryVld_i      (vld_q[query_set_i]),
        .victimWay_o   (qryVictim_d),
        .victimEvict_o (qryEvict_d)
    );

    // Flush FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FL_IDLE;
            sweepCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sweepCnt_q <= sweepCnt_d;
        end
    end

    // Flush FSM next state: one set per cycle, counter returns to 0 on exit.
    always_comb begin
        state_d    = state_q;
        sweepCnt_d = sweepCnt_q;
        case (state_q)
            FL_IDLE: begin
                if (flush_i) begin
                    state_d    = FL_SWEEP;
                    sweepCnt_d = '0;
                end
            end
            FL_SWEEP: begin
                if (sweepCnt_q == SET_W'(NUM_SETS - 1)) begin
                    state_d    = FL_IDLE;
                    sweepCnt_d = '0;
                end else begin
                    sweepCnt_d = sweepCnt_q + SET_W'(1);
                end
            end
            default: begin
                state_d    = FL_IDLE;
                sweepCnt_d = '0;
            end
        endcase
    end

    // Flush FSM outputs.
    always_comb begin
        busy_o     = sweeping;
        op_ready_o = !sweeping;
    end

    // LRU state array. The sweep write takes priority; an op accepted in the
    // same cycle flush_i is raised still lands and is overwritten later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                age_q[s] <= resetAge();
                vld_q[s] <= '0;
            end
        end else if (sweeping) begin
            age_q[sweepCnt_q] <= resetAge();
            vld_q[sweepCnt_q] <= '0;
        end else if (opEff != LRU_NOP) begin
            age_q[op_set_i] <= opAge_d;
            vld_q[op_set_i] <= opVld_d;
        end
    end

    // Victim result register. It samples the array before this edge's
    // update, so a same-cycle op to the queried set is not visible.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            victimValid_q <= 1'b0;
            victimWay_q   <= '0;
            victimEvict_q <= 1'b0;
        end else begin
            victimValid_q <= query_valid_i && !sweeping;
            if (query_valid_i && !sweeping) begin
                victimWay_q   <= qryVictim_d;
                victimEvict_q <= qryEvict_d;
            end
        end
    end

    assign victim_valid_o = victimValid_q;
    assign victim_way_o   = victimWay_q;
    assign victim_evict_o = victimEvict_q;

endmodule
